fp_divider: RTL and testbench
=============================

# fp_divider

Iterative IEEE-754 single-precision divider and companion to the existing floating-point multiplier datapath. It accepts two 32-bit operands on a start pulse and computes the sign and exponent. It divides the 24-bit mantissas with a radix-2 restoring loop, rounds to nearest-even, and returns the packed 32-bit quotient with a one-cycle done pulse. It sits beside the multiplier in the FP unit and uses the same operand and result format.

## Interface
- No parameters; widths fixed to single precision.
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; returns block to IDLE.
- start  in  1  operation request; sampled only in IDLE.
- dividendo  in  32  IEEE-754 dividend.
- divisor  in  32  IEEE-754 divisor.
- quociente  out  32  packed result; held until next accepted start.
- done  out  1  one-cycle pulse when quociente is valid.
- busy  out  1  high in every state except IDLE.
- div_zero  out  1  set with done when the divisor is zero and the dividend is nonzero; held with quociente.

## Operation
- **Reset values:** quociente=0, done=0, busy=0, div_zero=0, state=IDLE, and all internal registers 0.
- **Operand latching:** on start in IDLE, latch both operands. Later changes on the inputs have no effect.
- **Operand classes:**
  - exp==0 is zero; denormals are flushed to zero.
  - exp==255 is Inf/NaN.
  - otherwise the operand is normal, with mantissa {1, frac}.
- **Sign:** s = dividendo[31] ^ divisor[31].
- **CHECK state** resolves special cases, in this priority order:
  - either operand is Inf/NaN -> 0x7FC00000.
  - both operands are zero -> 0x7FC00000.
  - divisor is zero -> {s, 0xFF, 0}, with div_zero=1.
  - dividend is zero -> {s, 31'b0}.
  - otherwise go to DIVIDE.
- **Exponent:** computed as a signed 10-bit value, E = e1 - e2 + 127.
- **DIVIDE state:**
  - Setup: R (25 bits) = m1 and D = m2. The 5-bit counter runs 0..25.
  - Each cycle: if R >= D, set qbit=1 and R = R - D; otherwise qbit=0. Then R = R << 1, and shift q (26 bits) left with qbit entering at the LSB.
  - After 26 iterations, go to ROUND.
- **ROUND state:**
  - Normalize:
    - if q[25]=1: f = q[24:2], g = q[1], st = q[0] | (R != 0).
    - else: f = q[23:1], g = q[0], st = (R != 0), and E = E - 1.
  - Round up when g & (st | f[0]). A carry out of f sets f=0 and E = E + 1.
  - Final exponent check:
    - E >= 255 -> {s, 0xFF, 0}.
    - E <= 0 -> {s, 31'b0} (flush to zero, no denormal output).
    - otherwise the result is {s, E[7:0], f}.
- **DONE state:** assert done for one cycle, then return to IDLE.

## Timing
- **FSM:** IDLE -> CHECK -> (DONE | DIVIDE) -> ROUND -> DONE -> IDLE.
- **Normal path:**
  - edge 0 samples start.
  - edge 1 leaves CHECK.
  - edges 2..27 perform the 26 iterations.
  - edge 28 registers quociente and enters DONE.
  - done is high between edges 28 and 29.
- **Special path:** edge 1 registers quociente and enters DONE. done is high between edges 1 and 2.
- **busy:** high from edge 0 until the edge that returns to IDLE. It is low in the same cycle in which done falls.
- **start while busy:** ignored, not queued. A start in the cycle after done (IDLE) is accepted.
- **Back-to-back operation:** the minimum spacing between accepted starts is 30 cycles on the normal path and 3 on the special path.
- **quociente and div_zero:** update only on the edge that enters DONE. div_zero is cleared on that same edge for non-div-by-zero results.
- **Reset mid-operation:** asynchronously forces IDLE and zeroes all outputs. The partial result is discarded, and no done is issued.

## Test plan
- **Exact division:** 0x40C00000 / 0x40000000 (6/2) -> quociente=0x40400000 and div_zero=0. done rises 28 cycles after start, and busy is high throughout.
- **Rounding:** 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB; the guard and sticky bits round up. Also 0xC0000000 / 0x3F800000 -> 0xC0000000.
- **Special cases:**
  - 0x3F800000 / 0x00000000 -> 0x7F800000 with div_zero=1, done 1 cycle after the start edge.
  - 0x80000000 / 0x40A00000 -> 0x80000000.
  - 0 / 0 -> 0x7FC00000.
- **Exponent range:**
  - 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow).
  - 0x00800000 / 0x40000000 -> 0x00000000 (flush).
- **Handshake:**
  - start is asserted again at cycle 10 of an operation -> ignored; the result matches the first operands.
  - operands change after the start edge -> result unaffected.
  - new start the cycle after done -> accepted.
- **Reset mid-divide:** assert reset at cycle 12 -> outputs are 0 immediately, with no done. A subsequent 6/2 operation completes correctly.

Source files
------------

// File: rtl/fp_divider_if.sv
// Start/result handshake for the iterative single-precision divider.
// The master drives the operands and the start request; the slave returns the result.
interface fp_divider_if;
    logic        start;
    logic [31:0] dividendo;
    logic [31:0] divisor;
    logic [31:0] quociente;
    logic        done;
    logic        busy;
    logic        div_zero;

    modport master (
        output start, dividendo, divisor,
        input  quociente, done, busy, div_zero
    );

    modport slave (
        input  start, dividendo, divisor,
        output quociente, done, busy, div_zero
    );
endinterface

// File: rtl/fp_divider.sv
// IEEE-754 single-precision divider: radix-2 restoring mantissa loop with round-to-nearest-even.
// Denormal inputs are flushed to zero, and underflowing results flush to zero.
module fp_divider (
    input logic        clock,
    input logic        reset,
    fp_divider_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] DIVIDE = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam logic [31:0] QNAN  = 32'h7FC00000;

    logic [2:0]        state;
    logic [31:0]       a, b;
    logic              s;
    logic signed [9:0] e;
    logic [24:0]       r;
    logic [23:0]       d;
    logic [25:0]       q;
    logic [4:0]        cnt;
    logic [31:0]       quo;
    logic              dz;

    logic              a_zero, b_zero, a_spec, b_spec, sgn;
    logic              ge;
    logic [24:0]       rsel;
    logic [22:0]       f_raw;
    logic              g, st, up;
    logic [23:0]       rnd;
    logic signed [9:0] e_n, e_r;
    logic [31:0]       res;

    assign a_zero = (a[30:23] == 8'd0);
    assign b_zero = (b[30:23] == 8'd0);
    assign a_spec = (a[30:23] == 8'hFF);
    assign b_spec = (b[30:23] == 8'hFF);
    assign sgn    = a[31] ^ b[31];

    assign ge   = (r >= {1'b0, d});
    assign rsel = ge ? (r - {1'b0, d}) : r;

    // Normalise the 26-bit quotient, then round to nearest-even with sticky from the remainder
    always_comb begin
        f_raw = q[23:1];
        g     = q[0];
        st    = |r;
        e_n   = e - 10'sd1;
        if (q[25]) begin
            f_raw = q[24:2];
            g     = q[1];
            st    = q[0] | (|r);
            e_n   = e;
        end
        up  = g & (st | f_raw[0]);
        rnd = {1'b0, f_raw} + {23'd0, up};
        e_r = e_n + $signed({9'd0, rnd[23]});
        if (e_r >= 10'sd255)
            res = {s, 8'hFF, 23'd0};
        else if (e_r <= 10'sd0)
            res = {s, 31'd0};
        else
            res = {s, e_r[7:0], rnd[22:0]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            s     <= 1'b0;
            e     <= '0;
            r     <= '0;
            d     <= '0;
            q     <= '0;
            cnt   <= '0;
            quo   <= '0;
            dz    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a     <= bus.dividendo;
                        b     <= bus.divisor;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    s   <= sgn;
                    e   <= $signed({2'b0, a[30:23]}) - $signed({2'b0, b[30:23]}) + 10'sd127;
                    r   <= {2'b01, a[22:0]};
                    d   <= {1'b1, b[22:0]};
                    q   <= '0;
                    cnt <= '0;
                    if (a_spec || b_spec) begin
                        quo   <= QNAN;
                        dz    <= 1'b0;
                        state <= DONE;
                    end else if (a_zero && b_zero) begin
                        quo   <= QNAN;
                        dz    <= 1'b0;
                        state <= DONE;
                    end else if (b_zero) begin
                        quo   <= {sgn, 8'hFF, 23'd0};
                        dz    <= 1'b1;
                        state <= DONE;
                    end else if (a_zero) begin
                        quo   <= {sgn, 31'd0};
                        dz    <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    r   <= {rsel[23:0], 1'b0};
                    q   <= {q[24:0], ge};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd25)
                        state <= ROUND;
                end
                ROUND: begin
                    quo   <= res;
                    dz    <= 1'b0;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quociente = quo;
    assign bus.div_zero  = dz;
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed table, handshake/reset
// sequences and randomized operands against an integer reference model.
module tb_fp_divider;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fp_divider_if bus ();

    fp_divider dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        dz;
        int          lat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact integer quotient with 40 fractional bits, rounded to 24 significant bits
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic dz, output int lat);
        int unsigned ea, eb;
        logic s;
        longint unsigned m1, m2, n, qq, rr, mant, lo, half;
        int e, sh;
        bit upr;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        s   = a[31] ^ b[31];
        dz  = 1'b0;
        lat = 1;
        if (ea == 255 || eb == 255) q = 32'h7FC00000;
        else if (ea == 0 && eb == 0) q = 32'h7FC00000;
        else if (eb == 0) begin
            q  = {s, 8'hFF, 23'd0};
            dz = 1'b1;
        end else if (ea == 0) q = {s, 31'd0};
        else begin
            lat = 28;
            m1 = 64'(1 << 23) + 64'(a[22:0]);
            m2 = 64'(1 << 23) + 64'(b[22:0]);
            n  = m1 << 40;
            qq = n / m2;
            rr = n % m2;
            e  = int'(ea) - int'(eb) + 127;
            if (qq >= (64'd1 << 40)) sh = 17;
            else begin
                sh = 16;
                e  = e - 1;
            end
            mant = qq >> sh;
            lo   = qq & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            upr  = (lo > half) || (lo == half && (rr != 0 || mant[0]));
            mant = mant + 64'(upr);
            if (mant == (64'd1 << 24)) begin
                mant = 64'd1 << 23;
                e    = e + 1;
            end
            if (e >= 255) q = {s, 8'hFF, 23'd0};
            else if (e <= 0) q = {s, 31'd0};
            else q = {s, e[7:0], mant[22:0]};
        end
    endfunction

    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit junk,
                       output logic [31:0] q, output logic dz, output int lat);
        int w, nb;
        w = 0;
        while (bus.busy && w < 100) begin
            @(posedge clock);
            #1;
            w++;
        end
        bus.dividendo = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start     = 1'b0;
        bus.dividendo = $urandom;
        bus.divisor   = $urandom;
        lat = -1;
        nb  = 0;
        for (int k = 1; k <= 60; k++) begin
            if (junk && k == 10) bus.start = 1'b1;
            if (junk && k == 11) bus.start = 1'b0;
            @(posedge clock);
            #1;
            if (!bus.busy) nb++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        q  = bus.quociente;
        dz = bus.div_zero;
        check("busy_during_op", 32'(nb), 32'd0);
        @(posedge clock);
        #1;
        check("done_pulse_falls", {31'd0, bus.done}, 32'd0);
        check("busy_low_after", {31'd0, bus.busy}, 32'd0);
    endtask

    vec_t tv[11];
    logic [31:0] rq, eq;
    logic rdz, edz;
    int rlat, elat, ndone;

    initial begin
        tv[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28};
        tv[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28};
        tv[2]  = '{32'hC0000000, 32'h3F800000, 32'hC0000000, 1'b0, 28};
        tv[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1};
        tv[4]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1};
        tv[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1};
        tv[6]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 28};
        tv[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 28};
        tv[8]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1};
        tv[9]  = '{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, 1};
        tv[10] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.dividendo = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_quociente", bus.quociente, 32'd0);
        check("reset_flags", {29'd0, bus.done, bus.busy, bus.div_zero}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 11; i++) begin
            run(tv[i].a, tv[i].b, 1'b0, rq, rdz, rlat);
            check($sformatf("vec%0d_q", i), rq, tv[i].q);
            check($sformatf("vec%0d_dz", i), {31'd0, rdz}, {31'd0, tv[i].dz});
            check($sformatf("vec%0d_lat", i), 32'(rlat), 32'(tv[i].lat));
        end

        run(32'h40C00000, 32'h40000000, 1'b1, rq, rdz, rlat);
        check("restart_ignored_q", rq, 32'h40400000);
        check("restart_ignored_lat", 32'(rlat), 32'd28);

        run(32'h3F800000, 32'h00000000, 1'b0, rq, rdz, rlat);
        bus.dividendo = 32'h40C00000;
        bus.divisor   = 32'h40000000;
        bus.start     = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_quociente", bus.quociente, 32'd0);
        check("midreset_flags", {29'd0, bus.done, bus.busy, bus.div_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.done) ndone++;
        end
        check("midreset_no_done", 32'(ndone), 32'd0);
        run(32'h40C00000, 32'h40000000, 1'b0, rq, rdz, rlat);
        check("after_reset_q", rq, 32'h40400000);
        check("after_reset_lat", 32'(rlat), 32'd28);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 != 0) begin
                ra[30:23] = 8'($urandom_range(60, 190));
                rb[30:23] = 8'($urandom_range(60, 190));
            end
            ref_div(ra, rb, eq, edz, elat);
            run(ra, rb, 1'b0, rq, rdz, rlat);
            check($sformatf("rand_q %h/%h", ra, rb), rq, eq);
            check("rand_dz", {31'd0, rdz}, {31'd0, edz});
            check("rand_lat", 32'(rlat), 32'(elat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
